lamp_sequence_monitor: RTL and testbench

Checker stage directly downstream of the cyclic lamp FSM. It samples the 3-bit RGY lamp bus every clock and tracks the expected Red → Green → Yellow → Red cycle. It reports illegal lamp codes, out-of-order transitions and dwell-time violations, and counts completed cycles. It feeds status and error logic; it never drives the lamp.

---
 rtl/lamp_mon_pkg.sv | 49 ++++
 rtl/lamp_dwell_counter.sv | 38 +++
 rtl/lamp_sequence_monitor.sv | 137 +++++++++++++
 tb/tb_lamp_sequence_monitor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lamp_mon_pkg.sv
// Shared types and constants for the lamp sequence monitor.
// Lamp codes are written MSB-first so that 3'b100 lands on light[0] (Red) of a [0:2] bus.
package lamp_mon_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } phase_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CODE  = 3'd1;
  localparam logic [2:0] ERR_SEQ   = 3'd2;
  localparam logic [2:0] ERR_SHORT = 3'd3;
  localparam logic [2:0] ERR_LONG  = 3'd4;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_G = 3'b010;
  localparam logic [2:0] LAMP_Y = 3'b001;

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == LAMP_R) || (v == LAMP_G) || (v == LAMP_Y);
  endfunction

  // Non-one-hot codes map to SYNC; callers qualify with is_one_hot first.
  function automatic phase_e code_to_phase(input logic [2:0] v);
    phase_e p;
    case (v)
      LAMP_R:  p = RED;
      LAMP_G:  p = GREEN;
      LAMP_Y:  p = YELLOW;
      default: p = SYNC;
    endcase
    return p;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      RED:     n = GREEN;
      GREEN:   n = YELLOW;
      YELLOW:  n = RED;
      default: n = SYNC;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// Saturating per-phase dwell counter; only instantiated when LAMP_MON_DWELL_CHECK_EN is defined.
// max_hit is combinational and flags the edge on which dwell will first reach MAX_DWELL.
module lamp_dwell_counter #(
  parameter int MAX_DWELL = 16,
  parameter int DW_W      = 5
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load1,
  input  logic            inc,
  output logic [DW_W-1:0] dwell,
  output logic            max_hit
);

  localparam logic [DW_W-1:0] L_MAX = DW_W'(MAX_DWELL);
  localparam logic [DW_W-1:0] L_ONE = DW_W'(1);

  logic [DW_W-1:0] r_dwell;

  // Neither load1 nor inc means the monitor is resynchronising, so the count is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell <= '0;
    end else if (load1) begin
      r_dwell <= L_ONE;
    end else if (inc) begin
      if (r_dwell < L_MAX) begin
        r_dwell <= r_dwell + L_ONE;
      end
    end else begin
      r_dwell <= '0;
    end
  end

  assign dwell   = r_dwell;
  assign max_hit = inc && !load1 && (r_dwell == (L_MAX - L_ONE));

endmodule

// File: rtl/lamp_sequence_monitor.sv
// Checks the R->G->Y->R lamp cycle, flags CODE/SEQ/SHORT/LONG errors and counts cycles.
// Dwell checking (SHORT/LONG) is compiled in only when LAMP_MON_DWELL_CHECK_EN is defined.
module lamp_sequence_monitor
  import lamp_mon_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 16,
  parameter int CNT_W     = 8,
  parameter int DW_W      = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [0:2]       light,
  output logic             err_valid,
  output logic [2:0]       err_code,
  output logic             err_sticky,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] cycle_count
);

  phase_e           r_phase;
  logic             r_err_valid;
  logic [2:0]       r_err_code;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_cycle_count;

  phase_e     w_phase_nxt;
  phase_e     w_sample_phase;
  logic       w_sample_legal;
  logic       w_err_valid_nxt;
  logic [2:0] w_err_code_nxt;
  logic       w_cnt_inc;
  logic       w_load1;
  logic       w_inc;
  logic       w_short;
  logic       w_long;

  assign w_sample_legal = is_one_hot(light);
  assign w_sample_phase = code_to_phase(light);

`ifdef LAMP_MON_DWELL_CHECK_EN
  logic [DW_W-1:0] w_dwell;
  logic            w_max_hit;

  lamp_dwell_counter #(
    .MAX_DWELL (MAX_DWELL),
    .DW_W      (DW_W)
  ) u_dwell (
    .clock   (clock),
    .reset_n (reset_n),
    .load1   (w_load1),
    .inc     (w_inc),
    .dwell   (w_dwell),
    .max_hit (w_max_hit)
  );

  assign w_short = (w_dwell < DW_W'(MIN_DWELL));
  assign w_long  = w_max_hit;
`else
  logic w_unused_cfg;

  assign w_short      = 1'b0;
  assign w_long       = 1'b0;
  assign w_unused_cfg = ^{w_load1, w_inc, DW_W'(MIN_DWELL), DW_W'(MAX_DWELL)};
`endif

  // Branch order encodes error priority CODE > SEQ > SHORT > LONG; a phase change masks LONG.
  always_comb begin
    w_phase_nxt     = r_phase;
    w_err_valid_nxt = 1'b0;
    w_err_code_nxt  = ERR_NONE;
    w_cnt_inc       = 1'b0;
    w_load1         = 1'b0;
    w_inc           = 1'b0;
    case (r_phase)
      SYNC: begin
        if (w_sample_legal) begin
          w_phase_nxt = w_sample_phase;
          w_load1     = 1'b1;
        end
      end
      default: begin
        if (!w_sample_legal) begin
          w_phase_nxt     = SYNC;
          w_err_valid_nxt = 1'b1;
          w_err_code_nxt  = ERR_CODE;
        end else if (w_sample_phase == r_phase) begin
          w_inc = 1'b1;
          if (w_long) begin
            w_err_valid_nxt = 1'b1;
            w_err_code_nxt  = ERR_LONG;
          end
        end else begin
          w_phase_nxt = w_sample_phase;
          w_load1     = 1'b1;
          if (w_sample_phase != next_phase(r_phase)) begin
            w_err_valid_nxt = 1'b1;
            w_err_code_nxt  = ERR_SEQ;
          end else begin
            w_cnt_inc = (r_phase == YELLOW);
            if (w_short) begin
              w_err_valid_nxt = 1'b1;
              w_err_code_nxt  = ERR_SHORT;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase       <= SYNC;
      r_err_valid   <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_err_sticky  <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_err_valid <= w_err_valid_nxt;
      r_err_code  <= w_err_code_nxt;
      if (w_err_valid_nxt) begin
        r_err_sticky <= 1'b1;
      end
      if (w_cnt_inc) begin
        r_cycle_count <= r_cycle_count + 1'b1;
      end
    end
  end

  assign err_valid   = r_err_valid;
  assign err_code    = r_err_code;
  assign err_sticky  = r_err_sticky;
  assign phase       = r_phase;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Directed self-checking bench for lamp_sequence_monitor; dutA uses MIN=1/MAX=16/CNT_W=2,
// dutB uses MIN=3/MAX=5 for the dwell checks. Honours LAMP_MON_DWELL_CHECK_EN.
module tb_lamp_sequence_monitor;
  import lamp_mon_pkg::*;

`ifdef LAMP_MON_DWELL_CHECK_EN
  localparam bit DwellEn = 1'b1;
`else
  localparam bit DwellEn = 1'b0;
`endif

  logic       clock;
  logic       resetN;
  logic [0:2] lightA;
  logic [0:2] lightB;

  logic       errValidA, errStickyA;
  logic [2:0] errCodeA;
  logic [1:0] phaseA;
  logic [1:0] countA;

  logic       errValidB, errStickyB;
  logic [2:0] errCodeB;
  logic [1:0] phaseB;
  logic [7:0] countB;

  int compared   = 0;
  int mismatched = 0;

  lamp_sequence_monitor #(
    .MIN_DWELL (1), .MAX_DWELL (16), .CNT_W (2), .DW_W (5)
  ) dutA (
    .clock (clock), .reset_n (resetN), .light (lightA),
    .err_valid (errValidA), .err_code (errCodeA), .err_sticky (errStickyA),
    .phase (phaseA), .cycle_count (countA)
  );

  lamp_sequence_monitor #(
    .MIN_DWELL (3), .MAX_DWELL (5), .CNT_W (8), .DW_W (5)
  ) dutB (
    .clock (clock), .reset_n (resetN), .light (lightB),
    .err_valid (errValidB), .err_code (errCodeB), .err_sticky (errStickyB),
    .phase (phaseB), .cycle_count (countB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one sample onto a bus, then look at the outputs 1 time unit after the edge.
  task automatic applyStimulus(input bit useB, input logic [2:0] code);
    if (useB) lightB = code;
    else      lightA = code;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    lightA = 3'b000;
    lightB = 3'b000;
    #12;
    compared++; if (errValidA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err_valid: got %b want 0", errValidA); end
    compared++; if (errCodeA !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_err_code: got %0d want 0", errCodeA); end
    compared++; if (errStickyA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err_sticky: got %b want 0", errStickyA); end
    compared++; if (phaseA !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_phase: got %0d want 0", phaseA); end
    compared++; if (countA !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", countA); end
    resetN = 1'b1;
  endtask

  task automatic test_nominal();
    logic [2:0] seq [7]      = '{LAMP_R, LAMP_G, LAMP_Y, LAMP_R, LAMP_G, LAMP_Y, LAMP_R};
    int         expPhase [7] = '{1, 2, 3, 1, 2, 3, 1};
    int         expCount [7] = '{0, 0, 0, 1, 1, 1, 2};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 3'b000);
      compared++; if (phaseA !== 2'd0 || errValidA !== 1'b0) begin mismatched++; $display("[TB] FAIL nominal_idle[%0d]: got phase %0d err %b want phase 0 err 0", i, phaseA, errValidA); end
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, seq[i]);
      compared++; if (phaseA !== 2'(expPhase[i])) begin mismatched++; $display("[TB] FAIL nominal_phase[%0d]: got %0d want %0d", i, phaseA, expPhase[i]); end
      compared++; if (errValidA !== 1'b0) begin mismatched++; $display("[TB] FAIL nominal_err[%0d]: got %b want 0", i, errValidA); end
      compared++; if (countA !== 2'(expCount[i])) begin mismatched++; $display("[TB] FAIL nominal_count[%0d]: got %0d want %0d", i, countA, expCount[i]); end
    end
  endtask

  task automatic test_illegal_code();
    applyStimulus(1'b0, LAMP_G);
    compared++; if (phaseA !== 2'd2) begin mismatched++; $display("[TB] FAIL code_enter_green: got %0d want 2", phaseA); end
    applyStimulus(1'b0, 3'b110);
    compared++; if (errValidA !== 1'b1) begin mismatched++; $display("[TB] FAIL code_err_valid: got %b want 1", errValidA); end
    compared++; if (errCodeA !== ERR_CODE) begin mismatched++; $display("[TB] FAIL code_err_code: got %0d want 1", errCodeA); end
    compared++; if (phaseA !== 2'd0) begin mismatched++; $display("[TB] FAIL code_phase: got %0d want 0", phaseA); end
    compared++; if (errStickyA !== 1'b1) begin mismatched++; $display("[TB] FAIL code_sticky: got %b want 1", errStickyA); end
    applyStimulus(1'b0, LAMP_R);
    compared++; if (phaseA !== 2'd1 || errValidA !== 1'b0) begin mismatched++; $display("[TB] FAIL code_resync: got phase %0d err %b want phase 1 err 0", phaseA, errValidA); end
    compared++; if (countA !== 2'd2) begin mismatched++; $display("[TB] FAIL code_count: got %0d want 2", countA); end
  endtask

  task automatic test_out_of_order();
    applyStimulus(1'b0, LAMP_Y);
    compared++; if (errValidA !== 1'b1 || errCodeA !== ERR_SEQ) begin mismatched++; $display("[TB] FAIL seq_err: got valid %b code %0d want valid 1 code 2", errValidA, errCodeA); end
    compared++; if (phaseA !== 2'd3) begin mismatched++; $display("[TB] FAIL seq_phase: got %0d want 3", phaseA); end
    compared++; if (countA !== 2'd2) begin mismatched++; $display("[TB] FAIL seq_count_hold: got %0d want 2", countA); end
    applyStimulus(1'b0, LAMP_R);
    compared++; if (errValidA !== 1'b0 || phaseA !== 2'd1) begin mismatched++; $display("[TB] FAIL seq_recover: got err %b phase %0d want err 0 phase 1", errValidA, phaseA); end
    compared++; if (countA !== 2'd3) begin mismatched++; $display("[TB] FAIL seq_count_inc: got %0d want 3", countA); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [4]      = '{LAMP_Y, LAMP_G, LAMP_R, LAMP_G};
    int         expPhase [4] = '{3, 2, 1, 2};
    logic       expValid [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, seq[i]);
      compared++; if (errValidA !== expValid[i]) begin mismatched++; $display("[TB] FAIL b2b_valid[%0d]: got %b want %b", i, errValidA, expValid[i]); end
      compared++; if (phaseA !== 2'(expPhase[i])) begin mismatched++; $display("[TB] FAIL b2b_phase[%0d]: got %0d want %0d", i, phaseA, expPhase[i]); end
      if (expValid[i]) begin
        compared++; if (errCodeA !== ERR_SEQ) begin mismatched++; $display("[TB] FAIL b2b_code[%0d]: got %0d want 2", i, errCodeA); end
      end
    end
    compared++; if (countA !== 2'd3) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d want 3", countA); end
  endtask

  task automatic test_reset_mid_phase();
    applyStimulus(1'b0, LAMP_Y);
    compared++; if (phaseA !== 2'd3 || errStickyA !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_pre: got phase %0d sticky %b want phase 3 sticky 1", phaseA, errStickyA); end
    #3;
    resetN = 1'b0;
    #1;
    compared++; if (phaseA !== 2'd0) begin mismatched++; $display("[TB] FAIL midrst_phase: got %0d want 0", phaseA); end
    compared++; if (errStickyA !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_sticky: got %b want 0", errStickyA); end
    compared++; if (countA !== 2'd0) begin mismatched++; $display("[TB] FAIL midrst_count: got %0d want 0", countA); end
    compared++; if (errValidA !== 1'b0 || errCodeA !== 3'd0) begin mismatched++; $display("[TB] FAIL midrst_err: got valid %b code %0d want 0 0", errValidA, errCodeA); end
    lightA = 3'b000;
    @(posedge clock);
    #1;
    resetN = 1'b1;
    applyStimulus(1'b0, 3'b000);
    applyStimulus(1'b0, LAMP_R);
    compared++; if (phaseA !== 2'd1 || errValidA !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_resume: got phase %0d err %b want phase 1 err 0", phaseA, errValidA); end
  endtask

  task automatic test_wrap();
    int expCount [5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, LAMP_G);
      applyStimulus(1'b0, LAMP_Y);
      applyStimulus(1'b0, LAMP_R);
      compared++; if (countA !== 2'(expCount[i])) begin mismatched++; $display("[TB] FAIL wrap_count[%0d]: got %0d want %0d", i, countA, expCount[i]); end
    end
    compared++; if (errStickyA !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_sticky: got %b want 0", errStickyA); end
  endtask

  task automatic test_dwell();
    logic expValid;
    lightA = 3'b000;
    applyStimulus(1'b1, LAMP_R);
    applyStimulus(1'b1, LAMP_R);
    compared++; if (phaseB !== 2'd1 || errValidB !== 1'b0) begin mismatched++; $display("[TB] FAIL dwell_red: got phase %0d err %b want phase 1 err 0", phaseB, errValidB); end
    applyStimulus(1'b1, LAMP_G);
    compared++; if (errValidB !== DwellEn) begin mismatched++; $display("[TB] FAIL dwell_short_valid: got %b want %b", errValidB, DwellEn); end
    if (DwellEn) begin
      compared++; if (errCodeB !== ERR_SHORT) begin mismatched++; $display("[TB] FAIL dwell_short_code: got %0d want 3", errCodeB); end
    end
    for (int k = 2; k <= 7; k++) begin
      applyStimulus(1'b1, LAMP_G);
      expValid = DwellEn && (k == 5);
      compared++; if (errValidB !== expValid) begin mismatched++; $display("[TB] FAIL dwell_long_valid[%0d]: got %b want %b", k, errValidB, expValid); end
      if (expValid) begin
        compared++; if (errCodeB !== ERR_LONG) begin mismatched++; $display("[TB] FAIL dwell_long_code: got %0d want 4", errCodeB); end
      end
    end
    applyStimulus(1'b1, LAMP_Y);
    compared++; if (errValidB !== 1'b0 || phaseB !== 2'd3) begin mismatched++; $display("[TB] FAIL dwell_g2y: got err %b phase %0d want err 0 phase 3", errValidB, phaseB); end
    applyStimulus(1'b1, LAMP_R);
    compared++; if (errValidB !== DwellEn) begin mismatched++; $display("[TB] FAIL dwell_y2r_short: got %b want %b", errValidB, DwellEn); end
    compared++; if (countB !== 8'd1) begin mismatched++; $display("[TB] FAIL dwell_y2r_count: got %0d want 1", countB); end
    compared++; if (errStickyB !== DwellEn) begin mismatched++; $display("[TB] FAIL dwell_sticky: got %b want %b", errStickyB, DwellEn); end
  endtask

  initial begin
    $display("[TB] start, dwell checks %s", DwellEn ? "enabled" : "disabled");
    test_reset();
    test_nominal();
    test_illegal_code();
    test_out_of_order();
    test_back_to_back();
    test_reset_mid_phase();
    test_wrap();
    test_dwell();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
